// File: rtl/pmem_fetch_pkg.sv
// Shared picoMIPS widths, fetch FSM states and the instruction word layout.
package picoMIPS_package;

   localparam int INST_WIDTH      = 6;
   localparam int ADDR_WIDTH      = 5;
   localparam int DATA_WIDTH      = 8;
   localparam int PMEM_WIDTH      = 8;
   localparam int PMEM_WORD_WIDTH = INST_WIDTH + 2 * ADDR_WIDTH + DATA_WIDTH;

   typedef enum logic [1:0] {FILL, RUN, HALTED} fetch_state_t;

   typedef struct packed {
      logic [INST_WIDTH-1:0] opcode;
      logic [ADDR_WIDTH-1:0] ra;
      logic [ADDR_WIDTH-1:0] rb;
      logic [DATA_WIDTH-1:0] imm;
   } instr_t;

endpackage

// File: rtl/pmem_fetch_if.sv
// Program-memory read bus: the fetch unit drives the address, pmem returns the word combinationally.
interface pmem_fetch_if
   import picoMIPS_package::*;
   ();

   logic [PMEM_WIDTH-1:0]      addr;
   logic [PMEM_WORD_WIDTH-1:0] dout;

   modport master (output addr, input dout);
   modport slave  (input addr, output dout);

endinterface

// File: rtl/pmem_fetch_pc_next.sv
// Combinational next-PC candidates: wrapped increment and branch target.
// PMEM_FETCH_REL_BRANCH_EN adds an ir_pc-relative target selected by branch_rel_i.
module pmem_fetch_pc_next
   import picoMIPS_package::*;
#(
   parameter logic [PMEM_WIDTH-1:0] LAST_ADDR = '1
) (
   input  logic [PMEM_WIDTH-1:0] pc_i,
   input  logic [PMEM_WIDTH-1:0] branch_target_i,
`ifdef PMEM_FETCH_REL_BRANCH_EN
   input  logic                  branch_rel_i,
   input  logic [PMEM_WIDTH-1:0] ir_pc_i,
   input  logic [DATA_WIDTH-1:0] imm_i,
`endif
   output logic [PMEM_WIDTH-1:0] pc_inc_o,
   output logic [PMEM_WIDTH-1:0] pc_tgt_o
);

   // Explicit wrap so a LAST_ADDR below the top of the address space still returns to 0.
   assign pc_inc_o = (pc_i == LAST_ADDR) ? '0 : pc_i + PMEM_WIDTH'(1);

`ifdef PMEM_FETCH_REL_BRANCH_EN
   localparam int SW  = PMEM_WIDTH + DATA_WIDTH + 2;
   localparam int MOD = int'(LAST_ADDR) + 1;

   logic signed [SW-1:0] rel_sum;
   logic signed [SW-1:0] rel_rem;

   always_comb begin
      rel_sum = $signed({{(SW-PMEM_WIDTH){1'b0}}, ir_pc_i})
              + $signed({{(SW-DATA_WIDTH){imm_i[DATA_WIDTH-1]}}, imm_i});
      // Signed % keeps the dividend's sign; fold negatives back into [0, LAST_ADDR].
      rel_rem = rel_sum % $signed(SW'(MOD));
      if (rel_rem[SW-1]) begin
         rel_rem = rel_rem + $signed(SW'(MOD));
      end
   end

   assign pc_tgt_o = branch_rel_i ? PMEM_WIDTH'(rel_rem) : branch_target_i;
`else
   assign pc_tgt_o = branch_target_i;
`endif

endmodule

// File: rtl/pmem_fetch.sv
// picoMIPS instruction fetch: PC, IR and FILL/RUN/HALTED control with branch squash.
// Define PMEM_FETCH_REL_BRANCH_EN for the branch_rel input (ir_pc + signed imm targets).
module pmem_fetch
   import picoMIPS_package::*;
#(
   parameter logic [PMEM_WIDTH-1:0] PC_RESET  = '0,
   parameter logic [PMEM_WIDTH-1:0] LAST_ADDR = '1
) (
   input  logic                  clk,
   input  logic                  nReset,
   pmem_fetch_if.master          pmem,
   input  logic                  stall,
   input  logic                  branch,
   input  logic [PMEM_WIDTH-1:0] branch_target,
`ifdef PMEM_FETCH_REL_BRANCH_EN
   input  logic                  branch_rel,
`endif
   input  logic                  halt,
   input  logic                  resume,
   output logic                  ir_valid,
   output logic [INST_WIDTH-1:0] opcode,
   output logic [ADDR_WIDTH-1:0] ra,
   output logic [ADDR_WIDTH-1:0] rb,
   output logic [DATA_WIDTH-1:0] imm,
   output logic [PMEM_WIDTH-1:0] ir_pc,
   output logic                  halted
);

   fetch_state_t          state_q, state_d;
   logic [PMEM_WIDTH-1:0] pc_q, pc_d;
   logic [PMEM_WIDTH-1:0] ir_pc_q, ir_pc_d;
   instr_t                ir_q, ir_d;
   logic                  ir_valid_q, ir_valid_d;
   logic [PMEM_WIDTH-1:0] pc_inc, pc_tgt;

   pmem_fetch_pc_next #(
      .LAST_ADDR (LAST_ADDR)
   ) u_pc_next (
      .pc_i            (pc_q),
      .branch_target_i (branch_target),
`ifdef PMEM_FETCH_REL_BRANCH_EN
      .branch_rel_i    (branch_rel),
      .ir_pc_i         (ir_pc_q),
      .imm_i           (ir_q.imm),
`endif
      .pc_inc_o        (pc_inc),
      .pc_tgt_o        (pc_tgt)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_pc_d    = ir_pc_q;
      ir_valid_d = ir_valid_q;
      unique case (state_q)
         FILL, RUN: begin
            if (branch) begin
               // The word fetched this cycle is on the wrong path: drop it.
               pc_d       = pc_tgt;
               ir_valid_d = 1'b0;
               state_d    = FILL;
            end else if (halt) begin
               ir_valid_d = 1'b0;
               state_d    = HALTED;
            end else if (!stall || state_q == FILL) begin
               ir_d       = instr_t'(pmem.dout);
               ir_pc_d    = pc_q;
               pc_d       = pc_inc;
               ir_valid_d = 1'b1;
               state_d    = RUN;
            end
         end
         HALTED: begin
            if (branch) begin
               pc_d    = pc_tgt;
               state_d = FILL;
            end else if (resume) begin
               state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nReset) begin
         state_q    <= FILL;
         pc_q       <= PC_RESET;
         ir_q       <= '0;
         ir_pc_q    <= '0;
         ir_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_pc_q    <= ir_pc_d;
         ir_valid_q <= ir_valid_d;
      end
   end

   assign pmem.addr = pc_q;
   assign ir_valid  = ir_valid_q;
   assign opcode    = ir_q.opcode;
   assign ra        = ir_q.ra;
   assign rb        = ir_q.rb;
   assign imm       = ir_q.imm;
   assign ir_pc     = ir_pc_q;
   assign halted    = (state_q == HALTED);

endmodule

// File: tb/tb_pmem_fetch.sv
// Bench for pmem_fetch: per-cycle expectations queued by the driver, popped on the falling edge.
module tb_pmem_fetch;
   import picoMIPS_package::*;

   localparam logic [PMEM_WIDTH-1:0] LAST = 8'h2F;

   typedef struct packed {
      logic [7:0] addr;
      logic       v;
      logic [7:0] irpc;
      logic       h;
      logic       zero;
   } exp_t;

   logic clk = 1'b0;
   logic nReset = 1'b0;
   logic stall = 1'b0, branch = 1'b0, halt = 1'b0, resume = 1'b0, branch_rel = 1'b0;
   logic [PMEM_WIDTH-1:0] branch_target = '0;
   logic                  ir_valid, halted;
   logic [INST_WIDTH-1:0] opcode;
   logic [ADDR_WIDTH-1:0] ra, rb;
   logic [DATA_WIDTH-1:0] imm;
   logic [PMEM_WIDTH-1:0] ir_pc;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];

   pmem_fetch_if pmem ();

   always #5 clk = ~clk;

   // Distinct per-field pattern so swapped or misplaced slices show up.
   function automatic instr_t word_at(input logic [7:0] k);
      instr_t w;
      w.opcode = k[5:0] ^ 6'h2A;
      w.ra     = k[4:0];
      w.rb     = ~k[4:0];
      w.imm    = k;
`ifdef PMEM_FETCH_REL_BRANCH_EN
      if (k == 8'd8) w.imm = 8'hFD;
`endif
      return w;
   endfunction

   assign pmem.dout = word_at(pmem.addr);

   pmem_fetch #(
      .PC_RESET  (8'h00),
      .LAST_ADDR (LAST)
   ) dut (
      .clk           (clk),
      .nReset        (nReset),
      .pmem          (pmem),
      .stall         (stall),
      .branch        (branch),
      .branch_target (branch_target),
`ifdef PMEM_FETCH_REL_BRANCH_EN
      .branch_rel    (branch_rel),
`endif
      .halt          (halt),
      .resume        (resume),
      .ir_valid      (ir_valid),
      .opcode        (opcode),
      .ra            (ra),
      .rb            (rb),
      .imm           (imm),
      .ir_pc         (ir_pc),
      .halted        (halted)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] a, input logic v, input logic [7:0] p,
                               input logic h);
      exp_t e;
      e.addr = a;
      e.v    = v;
      e.irpc = p;
      e.h    = h;
      e.zero = 1'b0;
      return e;
   endfunction

   function automatic exp_t mkz(input logic [7:0] a);
      exp_t e = mk(a, 1'b0, 8'h00, 1'b0);
      e.zero = 1'b1;
      return e;
   endfunction

   // Inputs for the next rising edge; e is the state expected right after it.
   task automatic cyc(input logic rn, input logic st, input logic br, input logic hl,
                      input logic rs, input logic rl, input logic [7:0] tgt, input exp_t e);
      @(negedge clk);
      #1;
      nReset        = rn;
      stall         = st;
      branch        = br;
      halt          = hl;
      resume        = rs;
      branch_rel    = rl;
      branch_target = tgt;
      exp_q.push_back(e);
   endtask

   task automatic run(input exp_t e);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, e);
   endtask

   always @(negedge clk) begin
      exp_t   e;
      instr_t w;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("addr", 32'(pmem.addr), 32'(e.addr));
         check("ir_valid", 32'(ir_valid), 32'(e.v));
         check("halted", 32'(halted), 32'(e.h));
         if (e.v) begin
            w = word_at(e.irpc);
            check("ir_pc", 32'(ir_pc), 32'(e.irpc));
            check("opcode", 32'(opcode), 32'(w.opcode));
            check("ra", 32'(ra), 32'(w.ra));
            check("rb", 32'(rb), 32'(w.rb));
            check("imm", 32'(imm), 32'(w.imm));
         end
         if (e.zero) begin
            check("rst_ir", 32'({opcode, ra, rb, imm}), 32'(0));
            check("rst_ir_pc", 32'(ir_pc), 32'(0));
         end
      end
   end

   initial begin
      // Reset, then free run: IR trails addr by one cycle.
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, mkz(8'h00));
      for (int k = 1; k <= 5; k++) run(mk(8'(k), 1'b1, 8'(k - 1), 1'b0));
      // Stall at pc=5.
      repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, mk(8'h05, 1'b1, 8'h04, 1'b0));
      run(mk(8'h06, 1'b1, 8'h05, 1'b0));
      run(mk(8'h07, 1'b1, 8'h06, 1'b0));
      // Branch at pc=7: one bubble, word 7 never valid.
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10, mk(8'h10, 1'b0, 8'h00, 1'b0));
      run(mk(8'h11, 1'b1, 8'h10, 1'b0));
      run(mk(8'h12, 1'b1, 8'h11, 1'b0));
      // Halt at pc=3; halt and stall ignored while halted.
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, mk(8'h02, 1'b0, 8'h00, 1'b0));
      run(mk(8'h03, 1'b1, 8'h02, 1'b0));
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, mk(8'h03, 1'b0, 8'h00, 1'b1));
      repeat (5) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, mk(8'h03, 1'b0, 8'h00, 1'b1));
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, mk(8'h03, 1'b0, 8'h00, 1'b0));
      run(mk(8'h04, 1'b1, 8'h03, 1'b0));
      // Branch and resume together while halted: branch target taken.
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, mk(8'h04, 1'b0, 8'h00, 1'b1));
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h20, mk(8'h20, 1'b0, 8'h00, 1'b0));
      run(mk(8'h21, 1'b1, 8'h20, 1'b0));
      // Wrap from LAST to 0 while in RUN.
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h2E, mk(8'h2E, 1'b0, 8'h00, 1'b0));
      run(mk(LAST, 1'b1, 8'h2E, 1'b0));
      run(mk(8'h00, 1'b1, LAST, 1'b0));
      run(mk(8'h01, 1'b1, 8'h00, 1'b0));
      // Branch, halt and stall together: branch wins.
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h08, mk(8'h08, 1'b0, 8'h00, 1'b0));
      run(mk(8'h09, 1'b1, 8'h08, 1'b0));
      // Reset mid-stall at pc=9.
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, mk(8'h09, 1'b1, 8'h08, 1'b0));
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, mkz(8'h00));
      run(mk(8'h01, 1'b1, 8'h00, 1'b0));
      // Reset while halted.
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, mk(8'h01, 1'b0, 8'h00, 1'b1));
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, mkz(8'h00));
      run(mk(8'h01, 1'b1, 8'h00, 1'b0));
`ifdef PMEM_FETCH_REL_BRANCH_EN
      // ir_pc=8, imm=-3 -> target 5; absolute target must be ignored.
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h08, mk(8'h08, 1'b0, 8'h00, 1'b0));
      run(mk(8'h09, 1'b1, 8'h08, 1'b0));
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h20, mk(8'h05, 1'b0, 8'h00, 1'b0));
      run(mk(8'h06, 1'b1, 8'h05, 1'b0));
`endif
      @(negedge clk);
      #1;
      check("sb_drain", 32'(exp_q.size()), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
